// File: rtl/vit_pkg.sv
// Shared Viterbi decoder definitions: metric type, modular compare, log2 helper.
package vit_pkg;

    localparam int unsigned PM_W_DEF = 8;
    // Widest metric the shared compare helper supports.
    localparam int unsigned PM_MAX_W = 32;

    typedef logic [PM_W_DEF-1:0] pm_t;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

    // a beats b iff (a - b) mod 2^w has its MSB set; equal values never beat each other.
    function automatic logic pm_better(input logic [PM_MAX_W-1:0] a,
                                       input logic [PM_MAX_W-1:0] b,
                                       input int unsigned         w);
        logic [PM_MAX_W-1:0] d;
        logic [PM_MAX_W-1:0] s;
        d = a - b;
        s = d >> (w - 1);
        return s[0];
    endfunction

endpackage

// File: rtl/pm_cmp_tree.sv
// Combinational winner-select tree across LANES metrics of one beat.
module pm_cmp_tree
    import vit_pkg::*;
#(
    parameter int unsigned LANES = 32,
    parameter int unsigned PM_W  = 8
) (
    input  logic [LANES*PM_W-1:0]  pm_i,
    output logic [PM_W-1:0]        win_pm_o,
    output logic [clog2(LANES)-1:0] win_lane_o
);

    localparam int unsigned LW = clog2(LANES);

    // Heap-ordered tree: leaves at LANES..2*LANES-1, root at 1; the left child always
    // holds the lower lanes, so it wins on a tie.
    always_comb begin : tree
        logic [PM_W-1:0] node_pm   [2*LANES];
        logic [LW-1:0]   node_lane [2*LANES];
        node_pm[0]   = '0;
        node_lane[0] = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            node_pm[LANES+k]   = pm_i[k*PM_W +: PM_W];
            node_lane[LANES+k] = LW'(k);
        end
        for (int unsigned n = LANES - 1; n >= 1; n--) begin
            if (pm_better(PM_MAX_W'(node_pm[2*n+1]), PM_MAX_W'(node_pm[2*n]), PM_W)) begin
                node_pm[n]   = node_pm[2*n+1];
                node_lane[n] = node_lane[2*n+1];
            end else begin
                node_pm[n]   = node_pm[2*n];
                node_lane[n] = node_lane[2*n];
            end
        end
        win_pm_o   = node_pm[1];
        win_lane_o = node_lane[1];
    end

endmodule

// File: rtl/pm_min_search.sv
// Streamed, back-pressurable minimum-path-metric search over one trellis step.
module pm_min_search
    import vit_pkg::*;
#(
    parameter int unsigned PM_W     = 8,
    parameter int unsigned N_STATES = 64,
    parameter int unsigned LANES    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*PM_W-1:0]      in_pm,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PM_W-1:0]            out_pm,
    output logic [clog2(N_STATES)-1:0] out_idx,
    output logic                       err_framing
);

    localparam int unsigned BEATS = N_STATES / LANES;
    localparam int unsigned IDX_W = clog2(N_STATES);
    localparam int unsigned LW    = clog2(LANES);
    localparam int unsigned CNT_W = (BEATS > 1) ? clog2(BEATS) : 1;

    logic             en;
    logic             accept;
    logic             is_last;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [PM_W-1:0]  tree_pm;
    logic [LW-1:0]    tree_lane;
    logic [IDX_W-1:0] s1_idx_d;
    logic             s1_valid_q, s1_last_q;
    logic [PM_W-1:0]  s1_pm_q;
    logic [IDX_W-1:0] s1_idx_q;
    logic             acc_valid_q;
    logic [PM_W-1:0]  acc_pm_q;
    logic [IDX_W-1:0] acc_idx_q;
    logic             take_s1;
    logic [PM_W-1:0]  cmb_pm_d;
    logic [IDX_W-1:0] cmb_idx_d;
    logic             out_valid_q;
    logic [PM_W-1:0]  out_pm_q;
    logic [IDX_W-1:0] out_idx_q;
    logic             err_q;

    pm_cmp_tree #(
        .LANES (LANES),
        .PM_W  (PM_W)
    ) u_tree (
        .pm_i       (in_pm),
        .win_pm_o   (tree_pm),
        .win_lane_o (tree_lane)
    );

    // Handshake, beat framing and the stage-2 merge against the accumulator.
    always_comb begin
        en         = !(out_valid_q && !out_ready);
        in_ready   = en && !rst;
        accept     = in_valid && in_ready;
        is_last    = (beat_cnt_q == CNT_W'(BEATS - 1));
        beat_cnt_d = is_last ? '0 : beat_cnt_q + 1'b1;
        s1_idx_d   = (IDX_W'(beat_cnt_q) << LW) | IDX_W'(tree_lane);
        // Accumulator holds earlier beats, so it keeps ties.
        take_s1    = !acc_valid_q ||
                     pm_better(PM_MAX_W'(s1_pm_q), PM_MAX_W'(acc_pm_q), PM_W);
        cmb_pm_d   = take_s1 ? s1_pm_q  : acc_pm_q;
        cmb_idx_d  = take_s1 ? s1_idx_q : acc_idx_q;
    end

    // Pipeline registers, beat counter, result holding and sticky framing error.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_pm_q     <= '0;
            s1_idx_q    <= '0;
            acc_valid_q <= 1'b0;
            acc_pm_q    <= '0;
            acc_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_pm_q    <= '0;
            out_idx_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            if (out_ready) out_valid_q <= 1'b0;
            if (accept && (in_last != is_last)) err_q <= 1'b1;
            if (en) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_pm_q    <= tree_pm;
                    s1_idx_q   <= s1_idx_d;
                    s1_last_q  <= is_last;
                    beat_cnt_q <= beat_cnt_d;
                end
                if (s1_valid_q) begin
                    if (s1_last_q) begin
                        out_pm_q    <= cmb_pm_d;
                        out_idx_q   <= cmb_idx_d;
                        out_valid_q <= 1'b1;
                        acc_valid_q <= 1'b0;
                    end else begin
                        acc_pm_q    <= cmb_pm_d;
                        acc_idx_q   <= cmb_idx_d;
                        acc_valid_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pm      = out_pm_q;
    assign out_idx     = out_idx_q;
    assign err_framing = err_q;

endmodule

// File: tb/tb_pm_min_search.sv
// Scoreboard bench for pm_min_search with N_STATES=64, LANES=32, PM_W=8.
module tb_pm_min_search;

    localparam int unsigned PM_W = 8;
    localparam int unsigned NS   = 64;
    localparam int unsigned LN   = 32;

    typedef struct packed {
        logic [7:0] pm;
        logic [5:0] idx;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [LN*8-1:0] in_pm = '0;
    logic            in_last = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [7:0]      out_pm;
    logic [5:0]      out_idx;
    logic            err_framing;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    exp_t        sb[$];
    logic [7:0]  step_m [NS];

    pm_min_search #(
        .PM_W     (PM_W),
        .N_STATES (NS),
        .LANES    (LN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pm       (in_pm),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pm      (out_pm),
        .out_idx     (out_idx),
        .err_framing (err_framing)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < NS; i++) step_m[i] = v;
    endtask

    // Reference: sequential scan, strict modular improvement only, so earliest index keeps ties.
    task automatic push_expected();
        exp_t e;
        e.pm  = step_m[0];
        e.idx = 6'd0;
        for (int i = 1; i < NS; i++) begin
            logic [7:0] d;
            d = step_m[i] - e.pm;
            if (d[7]) begin
                e.pm  = step_m[i];
                e.idx = 6'(i);
            end
        end
        sb.push_back(e);
    endtask

    // Present one beat (called just after a rising edge), return just after it is taken.
    task automatic drive_beat(input int b, input logic last);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < LN; k++) in_pm[k*8 +: 8] = step_m[b*LN + k];
        in_last  = last;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        sync();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_step(input bit bad_last0);
        drive_beat(0, bad_last0);
        drive_beat(1, 1'b1);
    endtask

    // Results are checked in the cycle before the consuming edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_result", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_pm",  out_pm,  e.pm);
                check("result_idx", out_idx, e.idx);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hold_pm;
        logic [5:0] hold_idx;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_err", err_framing, 0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_out_pm", out_pm, 0);
        check("post_rst_out_idx", out_idx, 0);
        check("post_rst_err", err_framing, 0);
        sync();

        // Basic minimum plus two-cycle latency
        fill(8'd100);
        step_m[5] = 8'd3;
        push_expected();
        send_step(1'b0);
        @(negedge clk);
        check("latency_t1", out_valid, 0);
        @(negedge clk);
        check("latency_t2", out_valid, 1);
        sync();

        // Wrap-around comparison
        fill(8'd10);
        step_m[0] = 8'd250;
        push_expected();
        send_step(1'b0);

        // All equal -> lowest index; strict minimum at the very last state
        fill(8'd42);
        push_expected();
        send_step(1'b0);
        step_m[63] = 8'd41;
        push_expected();
        send_step(1'b0);

        // Back-to-back random steps, spread kept under half the modulus
        for (int s = 0; s < 4; s++) begin
            logic [7:0] base;
            base = 8'($urandom_range(0, 255));
            for (int i = 0; i < NS; i++) step_m[i] = base + 8'($urandom_range(0, 100));
            push_expected();
            send_step(1'b0);
        end
        repeat (4) sync();

        // Backpressure: result A held while step B streams
        out_ready = 1'b0;
        fill(8'd60);
        step_m[50] = 8'd20;
        push_expected();
        send_step(1'b0);
        fill(8'd30);
        step_m[12] = 8'd5;
        push_expected();
        fork
            send_step(1'b0);
            begin
                repeat (2) @(negedge clk);
                check("bp_out_valid", out_valid, 1);
                hold_pm  = out_pm;
                hold_idx = out_idx;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check("bp_in_ready_low", in_ready, 0);
                    check("bp_pm_stable", out_pm, hold_pm);
                    check("bp_idx_stable", out_idx, hold_idx);
                end
                sync();
                out_ready = 1'b1;
            end
        join
        repeat (4) sync();

        // Framing: in_last on beat 0
        check("err_before_framing", err_framing, 0);
        fill(8'd80);
        step_m[33] = 8'd70;
        push_expected();
        drive_beat(0, 1'b1);
        @(negedge clk);
        check("err_set", err_framing, 1);
        sync();
        drive_beat(1, 1'b1);
        repeat (4) sync();
        check("err_sticky", err_framing, 1);

        // Reset mid-step drops partial state
        fill(8'd90);
        step_m[3] = 8'd1;
        drive_beat(0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 0);
        sync();
        rst = 1'b0;
        check("midrst_err_cleared", err_framing, 0);
        fill(8'd50);
        step_m[40] = 8'd7;
        push_expected();
        send_step(1'b0);

        // Drain
        for (int i = 0; i < 50 && sb.size() != 0; i++) sync();
        repeat (4) sync();
        check("sb_drained", sb.size(), 0);
        check("final_err", err_framing, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
